// File: rtl/word_to_byte.sv
// word_to_byte: serialises one BPW-byte word into single bytes for a byte-wide
// sink such as uart_tx. Byte 0 (bits [7:0]) goes out first, so a byte-to-word
// assembler at the far end rebuilds the original word. Every byte is framed by a
// low cycle on byte_valid, so edge-detecting sinks always see a rising edge.
module word_to_byte #(
    parameter int BPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid,
    input  logic [BPW*8-1:0] word_in,
    output logic             word_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ack,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [BPW*8-1:0] shreg_r, shreg_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [CW-1:0]    cnt_inc_s;
    logic [7:0]       byte_out_r, byte_out_s;
    logic             byte_valid_r, byte_valid_s;
    logic             word_ready_r, word_ready_s;
    logic             word_done_r, word_done_s;
    logic             busy_r, busy_s;

    // Select byte lane idx of a word; unused index values return zero.
    function automatic logic [7:0] lane(input logic [BPW*8-1:0] w, input logic [CW-1:0] idx);
        logic [7:0] res;
        res = 8'h00;
        for (int i = 0; i < BPW; i++) begin
            if (idx == i[CW-1:0]) begin
                res = w[i*8 +: 8];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign cnt_inc_s = cnt_r + CW'(1);

    // Next-state and next-output logic; word_done defaults low so it pulses one cycle.
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        cnt_s        = cnt_r;
        byte_out_s   = byte_out_r;
        byte_valid_s = byte_valid_r;
        word_ready_s = word_ready_r;
        word_done_s  = 1'b0;
        busy_s       = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (word_valid && word_ready_r) begin
                    shreg_s      = word_in;
                    byte_out_s   = word_in[7:0];
                    cnt_s        = '0;
                    byte_valid_s = 1'b1;
                    word_ready_s = 1'b0;
                    busy_s       = 1'b1;
                    state_s      = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (byte_ack) begin
                    byte_valid_s = 1'b0;
                    if (cnt_r == LAST_IDX) begin
                        word_done_s  = 1'b1;
                        word_ready_s = 1'b1;
                        busy_s       = 1'b0;
                        cnt_s        = '0;
                        state_s      = ST_IDLE;
                    end else begin
                        cnt_s      = cnt_inc_s;
                        byte_out_s = lane(shreg_r, cnt_inc_s);
                        state_s    = ST_GAP;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                byte_valid_s = 1'b1;
                state_s      = ST_SEND;
            end
            default: begin
                shreg_s      = '0;
                cnt_s        = '0;
                byte_out_s   = 8'h00;
                byte_valid_s = 1'b0;
                word_ready_s = 1'b1;
                busy_s       = 1'b0;
                state_s      = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-word abandons it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= '0;
            cnt_r        <= '0;
            byte_out_r   <= 8'h00;
            byte_valid_r <= 1'b0;
            word_ready_r <= 1'b1;
            word_done_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            cnt_r        <= cnt_s;
            byte_out_r   <= byte_out_s;
            byte_valid_r <= byte_valid_s;
            word_ready_r <= word_ready_s;
            word_done_r  <= word_done_s;
            busy_r       <= busy_s;
        end
    end

    assign word_ready = word_ready_r;
    assign byte_out   = byte_out_r;
    assign byte_valid = byte_valid_r;
    assign word_done  = word_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_word_to_byte.sv
// Self-checking bench for word_to_byte: a BPW=4 instance exercised with directed
// and random words, and a BPW=1 instance for the single-byte case.
module tb_word_to_byte;

    logic        clk = 1'b0;
    logic        rst;
    logic        word_valid;
    logic [31:0] word_in;
    logic        word_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ack;
    logic        word_done;
    logic        busy;

    logic        w1_valid;
    logic [7:0]  w1_in;
    logic        w1_ready;
    logic [7:0]  b1_out;
    logic        b1_valid;
    logic        b1_ack;
    logic        w1_done;
    logic        busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    word_to_byte #(.BPW(4)) dut4 (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word_in(word_in),
        .word_ready(word_ready), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ack(byte_ack), .word_done(word_done), .busy(busy)
    );

    word_to_byte #(.BPW(1)) dut1 (
        .clk(clk), .rst(rst), .word_valid(w1_valid), .word_in(w1_in),
        .word_ready(w1_ready), .byte_out(b1_out), .byte_valid(b1_valid),
        .byte_ack(b1_ack), .word_done(w1_done), .busy(busy1)
    );

    // Reference: byte k of a word, least significant byte first.
    function automatic logic [7:0] model_byte(input logic [31:0] w, input int k);
        return 8'((w >> (8 * k)) % 256);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if ({word_ready, byte_valid, word_done, busy, byte_out} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset4: ready,valid,done,busy,byte=%b%b%b%b %h required 1000 00",
                     word_ready, byte_valid, word_done, busy, byte_out);
        end
        n_checks++;
        if ({w1_ready, b1_valid, w1_done, busy1, b1_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset1: ready,valid,done,busy,byte=%b%b%b%b %h required 1000 00",
                     w1_ready, b1_valid, w1_done, busy1, b1_out);
        end
        rst = 1'b0;
        cycle();
    endtask

    // One full word on the BPW=4 instance: ack delay drawn from [dmin,dmax],
    // optional spurious acks while byte_valid is low.
    task automatic test_word(input logic [31:0] w, input int dmin, input int dmax,
                             input bit spurious, input string tag);
        int t;
        int d;
        t = 0;
        while (!word_ready && t < 40) begin
            cycle();
            t++;
        end
        n_checks++;
        if (word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_timeout: word_ready=%b required 1", tag, word_ready);
        end
        word_in    = w;
        word_valid = 1'b1;
        cycle();
        word_valid = 1'b0;
        word_in    = $urandom;
        n_checks++;
        if (byte_valid !== 1'b1 || busy !== 1'b1 || word_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept: valid,busy,ready=%b%b%b required 110", tag, byte_valid, busy, word_ready);
        end
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!byte_valid && t < 20) begin
                if (spurious) byte_ack = 1'($urandom_range(1, 0));
                cycle();
                t++;
            end
            byte_ack = 1'b0;
            d = int'($urandom_range(dmax, dmin));
            for (int j = 0; j < d; j++) begin
                n_checks++;
                if (byte_valid !== 1'b1 || byte_out !== model_byte(w, k)) begin
                    n_fail++;
                    $display("FAIL %s_hold%0d: valid=%b byte=%h required 1 %h", tag, k, byte_valid, byte_out, model_byte(w, k));
                end
                cycle();
            end
            n_checks++;
            if (byte_valid !== 1'b1 || byte_out !== model_byte(w, k)) begin
                n_fail++;
                $display("FAIL %s_byte%0d: valid=%b byte=%h required 1 %h", tag, k, byte_valid, byte_out, model_byte(w, k));
            end
            byte_ack = 1'b1;
            cycle();
            byte_ack = 1'b0;
            n_checks++;
            if (byte_valid !== 1'b0 || word_done !== (k == 3) || word_ready !== (k == 3)) begin
                n_fail++;
                $display("FAIL %s_after_ack%0d: valid,done,ready=%b%b%b required 0%b%b", tag, k,
                         byte_valid, word_done, word_ready, k == 3, k == 3);
            end
        end
        cycle();
        n_checks++;
        if (word_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: done,busy=%b%b required 00", tag, word_done, busy);
        end
    endtask

    task automatic test_ack_high();
        logic [31:0] w = 32'h04030201;
        word_in    = w;
        word_valid = 1'b1;
        byte_ack   = 1'b1;
        cycle();
        word_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (byte_valid !== ((i % 2) == 0) || (((i % 2) == 0) && byte_out !== model_byte(w, i / 2))) begin
                n_fail++;
                $display("FAIL ackhigh_c%0d: valid=%b byte=%h required %b %h", i + 1, byte_valid, byte_out,
                         (i % 2) == 0, model_byte(w, i / 2));
            end
            cycle();
        end
        n_checks++;
        if (word_done !== 1'b1 || word_ready !== 1'b1 || byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ackhigh_done: done,ready,valid=%b%b%b required 110", word_done, word_ready, byte_valid);
        end
        byte_ack = 1'b0;
        cycle();
    endtask

    task automatic test_ignore_busy();
        int t;
        word_in    = 32'hA5A5A5A5;
        word_valid = 1'b1;
        cycle();
        word_in = 32'h11111111;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!byte_valid && t < 20) begin
                cycle();
                t++;
            end
            if (k == 4) word_valid = 1'b0;
            n_checks++;
            if (byte_valid !== 1'b1 || byte_out !== ((k < 4) ? 8'hA5 : 8'h11)) begin
                n_fail++;
                $display("FAIL busy_byte%0d: valid=%b byte=%h required 1 %h", k, byte_valid, byte_out, (k < 4) ? 8'hA5 : 8'h11);
            end
            repeat ($urandom_range(2, 0)) cycle();
            byte_ack = 1'b1;
            cycle();
            byte_ack = 1'b0;
            if (k == 3) begin
                n_checks++;
                if (word_done !== 1'b1 || word_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_first_done: done,ready=%b%b required 11", word_done, word_ready);
                end
                cycle();
                n_checks++;
                if (byte_valid !== 1'b1 || byte_out !== 8'h11) begin
                    n_fail++;
                    $display("FAIL busy_back_to_back: valid=%b byte=%h required 1 11", byte_valid, byte_out);
                end
            end
        end
        n_checks++;
        if (word_done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_second_done: done=%b required 1", word_done);
        end
        cycle();
    endtask

    task automatic test_rst_mid();
        logic [31:0] w = $urandom;
        word_in    = w;
        word_valid = 1'b1;
        cycle();
        word_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (!byte_valid) cycle();
            n_checks++;
            if (byte_valid !== 1'b1 || byte_out !== model_byte(w, k)) begin
                n_fail++;
                $display("FAIL rst_pre_byte%0d: valid=%b byte=%h required 1 %h", k, byte_valid, byte_out, model_byte(w, k));
            end
            byte_ack = 1'b1;
            cycle();
            byte_ack = 1'b0;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++;
        if ({word_ready, byte_valid, word_done, busy, byte_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid: ready,valid,done,busy,byte=%b%b%b%b %h required 1000 00",
                     word_ready, byte_valid, word_done, busy, byte_out);
        end
        cycle();
        n_checks++;
        if (word_done !== 1'b0 || byte_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: done,valid=%b%b required 00", word_done, byte_valid);
        end
        test_word(32'hCAFEF00D, 0, 2, 1'b1, "cafe");
    endtask

    task automatic test_random();
        for (int i = 0; i < 15; i++) begin
            test_word($urandom, 0, 3, 1'b1, "rand");
        end
    endtask

    task automatic test_bpw1();
        w1_in    = 8'h5A;
        w1_valid = 1'b1;
        b1_ack   = 1'b1;
        cycle();
        w1_valid = 1'b0;
        n_checks++;
        if (b1_valid !== 1'b1 || b1_out !== 8'h5A || w1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bpw1_byte: valid=%b byte=%h ready=%b required 1 5a 0", b1_valid, b1_out, w1_ready);
        end
        cycle();
        n_checks++;
        if (b1_valid !== 1'b0 || w1_done !== 1'b1 || w1_ready !== 1'b1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bpw1_done: valid,done,ready,busy=%b%b%b%b required 0110", b1_valid, w1_done, w1_ready, busy1);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if (b1_valid !== 1'b0 || w1_done !== 1'b0) begin
                n_fail++;
                $display("FAIL bpw1_idle%0d: valid,done=%b%b required 00", i, b1_valid, w1_done);
            end
        end
        b1_ack = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        word_valid = 1'b0;
        word_in    = 32'h0;
        byte_ack   = 1'b0;
        w1_valid   = 1'b0;
        w1_in      = 8'h00;
        b1_ack     = 1'b0;
        #1;
        test_reset();
        test_word(32'hDEADBEEF, 3, 3, 1'b0, "deadbeef");
        test_ack_high();
        test_ignore_busy();
        test_rst_mid();
        test_random();
        test_bpw1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
